// File: rtl/lavadora_pkg.sv
// Shared washer-controller types: phase state codes, spin-time choices and default phase lengths.
// Imported by the spin executor and by the counters reused in the wash-time block.
package lavadora_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VACIADO = 3'd1,
        RAMPA   = 3'd2,
        CENTRI  = 3'd3,
        FRENADO = 3'd4,
        FIN     = 3'd5
    } estado_t;

    localparam int T_CENTRI_1 = 150;
    localparam int T_CENTRI_2 = 200;
    localparam int T_CENTRI_3 = 275;
    localparam int T_CENTRI_4 = 375;

    localparam int T_VACIADO_DEF = 10;
    localparam int T_RAMPA_DEF   = 5;
    localparam int T_FRENADO_DEF = 3;

    function automatic logic es_temporizado(input estado_t e);
        return (e == VACIADO) || (e == RAMPA) || (e == CENTRI) || (e == FRENADO);
    endfunction

endpackage

// File: rtl/ejecutor_centrifugado_if.sv
// Control, selection and status signals between the washer sequencer and the spin executor.
// The executor sits on the slave side; the sequencer (or a bench) drives the master side.
interface ejecutor_centrifugado_if #(
    parameter int CW = 9
);
    logic          iTick_1Hz;
    logic          iCentri_1;
    logic          iCentri_2;
    logic          iCentri_3;
    logic          iCentri_4;
    logic          iStart;
    logic          iPausa;
    logic          iCentrifugarL;
    logic          iLed_Motor;
    logic          iLed_Vaceando;
    logic [CW-1:0] iSegundos_Restantes;
    logic          iFin;
    logic          iError;
    logic [2:0]    estado;

    modport slave (
        input  iTick_1Hz, iCentri_1, iCentri_2, iCentri_3, iCentri_4,
               iStart, iPausa, iCentrifugarL,
        output iLed_Motor, iLed_Vaceando, iSegundos_Restantes, iFin, iError, estado
    );

    modport master (
        output iTick_1Hz, iCentri_1, iCentri_2, iCentri_3, iCentri_4,
               iStart, iPausa, iCentrifugarL,
        input  iLed_Motor, iLed_Vaceando, iSegundos_Restantes, iFin, iError, estado
    );

endinterface

// File: rtl/contador_segundos.sv
// Loadable seconds down-counter; load wins over tick, hold freezes it, never wraps below zero.
// last flags the tick that consumes the final second so the owner can leave its phase on that edge.
module contador_segundos #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] val,
    input  logic          tick,
    input  logic          hold,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic avanza;

    assign avanza = tick && !hold;
    assign last   = avanza && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (avanza && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ejecutor_centrifugado.sv
// Spin phase executor: drain -> spin-up -> timed spin -> brake -> one-cycle FIN, paced by a 1 Hz tick.
// Outputs follow the registered state; pause freezes timing and stops the motor, spin-enable low aborts.
module ejecutor_centrifugado
    import lavadora_pkg::*;
#(
    parameter int T_VACIADO = T_VACIADO_DEF,
    parameter int T_RAMPA   = T_RAMPA_DEF,
    parameter int T_FRENADO = T_FRENADO_DEF,
    parameter int CW        = 9
) (
    input  logic                   clk_in,
    input  logic                   iReset,
    ejecutor_centrifugado_if.slave bus
);

    estado_t       state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] cnt;
    logic          last;
    logic          load;
    logic [CW-1:0] load_val;

    logic [3:0]    sel;
    logic          sel_ok;
    logic [CW-1:0] sel_n;

    logic          motor_q, vac_q, fin_q, error_q;
    logic          motor_d, vac_d, fin_d, error_d;

    contador_segundos #(.CW(CW)) u_contador (
        .clk  (clk_in),
        .rst  (iReset),
        .load (load),
        .val  (load_val),
        .tick (bus.iTick_1Hz),
        .hold (bus.iPausa),
        .cnt  (cnt),
        .last (last)
    );

    assign sel = {bus.iCentri_4, bus.iCentri_3, bus.iCentri_2, bus.iCentri_1};

    always_comb begin
        sel_ok = 1'b1;
        sel_n  = '0;
        unique case (sel)
            4'b0001: sel_n = CW'(T_CENTRI_1);
            4'b0010: sel_n = CW'(T_CENTRI_2);
            4'b0100: sel_n = CW'(T_CENTRI_3);
            4'b1000: sel_n = CW'(T_CENTRI_4);
            default: sel_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            n_q     <= '0;
            motor_q <= 1'b0;
            vac_q   <= 1'b0;
            fin_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            motor_q <= motor_d;
            vac_q   <= vac_d;
            fin_q   <= fin_d;
            error_q <= error_d;
        end
    end

    // Abort is tested before last in every timed phase so it beats a coinciding final tick.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        load     = 1'b0;
        load_val = '0;
        error_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.iStart && bus.iCentrifugarL) begin
                    if (sel_ok) begin
                        state_d  = VACIADO;
                        n_d      = sel_n;
                        load     = 1'b1;
                        load_val = CW'(T_VACIADO);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            VACIADO: begin
                if (!bus.iCentrifugarL) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d  = RAMPA;
                    load     = 1'b1;
                    load_val = CW'(T_RAMPA);
                end
            end
            RAMPA: begin
                if (!bus.iCentrifugarL) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d  = CENTRI;
                    load     = 1'b1;
                    load_val = n_q;
                end
            end
            CENTRI: begin
                if (!bus.iCentrifugarL) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d  = FRENADO;
                    load     = 1'b1;
                    load_val = CW'(T_FRENADO);
                end
            end
            FRENADO: begin
                if (!bus.iCentrifugarL) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Leaving a phase for IDLE clears the leftover seconds.
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            load     = 1'b1;
            load_val = '0;
        end
    end

    always_comb begin
        motor_d = ((state_d == RAMPA) || (state_d == CENTRI)) && !bus.iPausa;
        vac_d   = es_temporizado(state_d);
        fin_d   = (state_d == FIN);
    end

    assign bus.iLed_Motor    = motor_q;
    assign bus.iLed_Vaceando = vac_q;
    assign bus.iFin          = fin_q;
    assign bus.iError        = error_q;
    assign bus.estado        = state_q;

    always_comb begin
        bus.iSegundos_Restantes = '0;
        unique case (state_q)
            VACIADO, RAMPA: bus.iSegundos_Restantes = n_q;
            CENTRI:         bus.iSegundos_Restantes = cnt;
            default:        bus.iSegundos_Restantes = '0;
        endcase
    end

endmodule

// File: doc/ejecutor_centrifugado.md
# ejecutor_centrifugado

Executes the spin (centrifugado) phase of the washer controller. Consumes the one-hot spin-time selection `iCentri_1..4` (150/200/275/375 s) and runs a drain → spin-up → timed spin → brake sequence, paced by a 1 Hz tick. Drives the motor and drain-pump LEDs, exposes remaining seconds to the display path, and pulses completion back to the top-level sequencer.

## Interface
- `T_VACIADO`, default 10: drain seconds before spin-up.
- `T_RAMPA`, default 5: spin-up seconds; not counted in spin time.
- `T_FRENADO`, default 3: brake seconds after spin.
- `CW`, default 9: width of the seconds counter; must hold 375.
- `clk_in`  in  1  system clock; only clock.
- `iReset`  in  1  asynchronous, active-high reset.
- `iTick_1Hz`  in  1  one-`clk_in`-cycle strobe, once per second.
- `iCentri_1`, `iCentri_2`, `iCentri_3`, `iCentri_4`  in  1 each  one-hot spin-time selection: 150, 200, 275, 375 s.
- `iStart`  in  1  level; start request, sampled in IDLE only.
- `iPausa`  in  1  level; freezes the sequence while high.
- `iCentrifugarL`  in  1  spin program enable; low aborts the sequence.
- `iLed_Motor`  out  1  motor drive.
- `iLed_Vaceando`  out  1  drain pump.
- `iSegundos_Restantes`  out  CW  seconds remaining for display.
- `iFin`  out  1  one-cycle completion pulse.
- `iError`  out  1  one-cycle pulse on an invalid selection at start.
- `estado`  out  3  current state code.

## Operation
- States and codes: IDLE=0, VACIADO=1, RAMPA=2, CENTRI=3, FRENADO=4, FIN=5.
- IDLE, with `iStart=1` and `iCentrifugarL=1`:
  - Exactly one `iCentri_x` set: latch the matching time N and go to VACIADO.
  - Zero or more than one set: stay in IDLE and pulse `iError`.
- Each timed state loads `cnt` with its duration on entry.
- Each unpaused tick decrements `cnt`. A tick with `cnt==1` leaves the state, so every phase lasts exactly its duration in ticks.
- Transitions: VACIADO → RAMPA → CENTRI → FRENADO → FIN → IDLE. FIN lasts exactly one `clk_in` cycle.
- Outputs per state:
  - VACIADO: `iLed_Vaceando=1`, `iLed_Motor=0`.
  - RAMPA and CENTRI: both `iLed_Motor=1` and `iLed_Vaceando=1`.
  - FRENADO: `iLed_Vaceando=1`, `iLed_Motor=0`.
  - IDLE and FIN: both 0.
- `iSegundos_Restantes`:
  - `cnt` in CENTRI.
  - N in VACIADO and RAMPA.
  - 0 in all other states.
- Pause:
  - While `iPausa=1`, ticks are ignored and state and `cnt` hold.
  - `iLed_Motor` is forced to 0; `iLed_Vaceando` is unchanged.
  - Pause and tick in the same cycle: pause wins and the tick is lost.
- `iStart` outside IDLE is ignored. Selection changes after latching are ignored.
- `iCentrifugarL=0` in any non-IDLE state aborts: next edge goes to IDLE, all outputs 0, no `iFin`.
- If abort and the final tick coincide, abort wins.

## Timing
- Reset values: state IDLE, `cnt=0`, N=0, and all outputs 0 (`iLed_Motor`, `iLed_Vaceando`, `iSegundos_Restantes`, `iFin`, `iError`, `estado`).
- All outputs are registered (Moore) and change on the `clk_in` edge after the causing event.
- Latency:
  - `iStart` sampled at edge k puts `estado=1` and `iLed_Vaceando=1` at k+1.
  - The final FRENADO tick at edge k gives `iFin=1` during k+1 and IDLE at k+2.
- Total run length: `T_VACIADO + T_RAMPA + N + T_FRENADO` ticks, plus paused time.
- Reset mid-run: outputs clear asynchronously and the sequence restarts only on a new `iStart`.
- `cnt` never underflows: a state is never entered with `cnt=0`.

## Structure
- Package `lavadora_pkg`:
  - State enum and codes.
  - Spin-time constants `T_CENTRI_1..4` (150, 200, 275, 375).
  - Default phase durations.
- Sub-module `contador_segundos`:
  - Loadable down-counter with `load`, `val`, `tick`, `hold` inputs.
  - Outputs `cnt` and `last` (`cnt==1 && tick && !hold`).
  - Reused by the wash-time block.
- The FSM and one-hot decode stay in the top module.

## Test plan
- Select `iCentri_1`, pulse `iStart`, ticks every 20 cycles → states 1/2/3/4/5 last 10/5/150/3 ticks; `iSegundos_Restantes` counts 150→1 in CENTRI; one `iFin` pulse; total 168 ticks.
- Select `iCentri_4` → CENTRI lasts 375 ticks; the counter shows 375 at entry, with no width overflow.
- `iStart` with none set, then with `iCentri_2` and `iCentri_3` both set → one `iError` pulse each; `estado` stays 0.
- In CENTRI with `cnt=100`, hold `iPausa` for 5 ticks, including one tick in the same cycle as pause rises → `cnt` stays 100 and `iLed_Motor=0`; after release, spin resumes with 100 s left.
- Drop `iCentrifugarL` in RAMPA → IDLE the next cycle, all outputs 0, no `iFin`; also drop it on the same cycle as the final FRENADO tick → no `iFin`.
- Assert `iReset` mid-CENTRI → outputs 0 immediately (asynchronous); after release the block stays IDLE until a new `iStart`.
